// File: rtl/dual_deque_pkg.sv
// Shared types and constants for the dual_deque arbiter and its round-robin helper.
package dual_deque_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ISSUE,
    ST_WAIT,
    ST_RESP
  } state_t;

  localparam logic OP_PUSH = 1'b0;
  localparam logic OP_POP  = 1'b1;
  localparam logic SEL_S0  = 1'b0;
  localparam logic SEL_S1  = 1'b1;
  localparam logic REQ_A   = 1'b0;
  localparam logic REQ_B   = 1'b1;

endpackage

// File: rtl/rr_arbiter2.sv
// Two-way round-robin grant: a lone requester wins outright, a tie goes to the
// requester that was not granted last.
module rr_arbiter2
  import dual_deque_pkg::*;
(
  input  logic [1:0] req,
  input  logic       last_grant,
  output logic       grant_valid,
  output logic       grant_id
);

  always_comb begin
    grant_valid = |req;
    grant_id    = REQ_A;
    if (req[REQ_A] && req[REQ_B]) begin
      grant_id = ~last_grant;
    end else if (req[REQ_B]) begin
      grant_id = REQ_B;
    end
  end

endmodule

// File: rtl/dual_deque_arbiter.sv
// Shares one dual_deque between requesters A and B; one command in flight at a time.
// States: IDLE grant+flag check | ISSUE single strobe | WAIT pop latency | RESP respond.
module dual_deque_arbiter
  import dual_deque_pkg::*;
#(
  parameter int DATA_W      = 8,
  parameter int POP_LATENCY = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              a_req,
  input  logic              a_op,
  input  logic              a_sel,
  input  logic [DATA_W-1:0] a_wdata,
  output logic              a_ready,
  output logic              a_rsp_valid,
  output logic              a_rsp_ok,
  output logic [DATA_W-1:0] a_rsp_data,
  input  logic              b_req,
  input  logic              b_op,
  input  logic              b_sel,
  input  logic [DATA_W-1:0] b_wdata,
  output logic              b_ready,
  output logic              b_rsp_valid,
  output logic              b_rsp_ok,
  output logic [DATA_W-1:0] b_rsp_data,
  output logic              dq_select,
  output logic              dq_push,
  output logic              dq_pop,
  output logic [DATA_W-1:0] dq_data_in,
  input  logic [DATA_W-1:0] dq_data_out,
  input  logic              dq_s0_empty,
  input  logic              dq_s0_full,
  input  logic              dq_s1_empty,
  input  logic              dq_s1_full,
  output logic              busy
);

  localparam int CNT_W = (POP_LATENCY > 1) ? $clog2(POP_LATENCY) : 1;

  state_t            state, state_n;
  logic              last_grant, last_grant_n;
  logic              cur_id, cur_id_n, cur_op, cur_op_n, cur_sel, cur_sel_n, cur_ok, cur_ok_n;
  logic [DATA_W-1:0] cur_wdata, cur_wdata_n;
  logic [CNT_W-1:0]  wait_cnt, wait_cnt_n;
  logic              a_ready_n, b_ready_n, a_rsp_valid_n, b_rsp_valid_n, rsp_ok_n;
  logic              dq_select_n, dq_push_n, dq_pop_n;
  logic [DATA_W-1:0] rsp_data_n, dq_data_in_n;
  logic              grant_valid, grant_id, win_op, win_sel, reject;
  logic [DATA_W-1:0] win_wdata;

  rr_arbiter2 u_arb (
    .req        ({b_req, a_req}),
    .last_grant (last_grant),
    .grant_valid(grant_valid),
    .grant_id   (grant_id)
  );

  assign win_op    = (grant_id == REQ_B) ? b_op    : a_op;
  assign win_sel   = (grant_id == REQ_B) ? b_sel   : a_sel;
  assign win_wdata = (grant_id == REQ_B) ? b_wdata : a_wdata;
  assign reject    = (win_op == OP_PUSH) ? ((win_sel == SEL_S1) ? dq_s1_full  : dq_s0_full)
                                         : ((win_sel == SEL_S1) ? dq_s1_empty : dq_s0_empty);

  always_comb begin
    state_n       = state;
    last_grant_n  = last_grant;
    cur_id_n      = cur_id;
    cur_op_n      = cur_op;
    cur_sel_n     = cur_sel;
    cur_ok_n      = cur_ok;
    cur_wdata_n   = cur_wdata;
    wait_cnt_n    = wait_cnt;
    a_ready_n     = 1'b0;
    b_ready_n     = 1'b0;
    a_rsp_valid_n = 1'b0;
    b_rsp_valid_n = 1'b0;
    rsp_ok_n      = 1'b0;
    rsp_data_n    = '0;
    dq_select_n   = 1'b0;
    dq_push_n     = 1'b0;
    dq_pop_n      = 1'b0;
    dq_data_in_n  = '0;
    unique case (state)
      ST_IDLE: begin
        if (grant_valid) begin
          a_ready_n   = (grant_id == REQ_A);
          b_ready_n   = (grant_id == REQ_B);
          cur_id_n    = grant_id;
          cur_op_n    = win_op;
          cur_sel_n   = win_sel;
          cur_wdata_n = win_wdata;
          cur_ok_n    = ~reject;
          state_n     = reject ? ST_RESP : ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        dq_select_n  = cur_sel;
        dq_data_in_n = cur_wdata;
        dq_push_n    = (cur_op == OP_PUSH);
        dq_pop_n     = (cur_op == OP_POP);
        wait_cnt_n   = CNT_W'(POP_LATENCY - 1);
        state_n      = (cur_op == OP_POP) ? ST_WAIT : ST_RESP;
      end
      ST_WAIT: begin
        if (wait_cnt == '0) begin
          state_n = ST_RESP;
        end else begin
          wait_cnt_n = wait_cnt - CNT_W'(1);
        end
      end
      ST_RESP: begin
        // Pop data becomes valid on dq_data_out while we sit here, so it is captured now.
        a_rsp_valid_n = (cur_id == REQ_A);
        b_rsp_valid_n = (cur_id == REQ_B);
        rsp_ok_n      = cur_ok;
        rsp_data_n    = (cur_ok && cur_op == OP_POP) ? dq_data_out : '0;
        last_grant_n  = cur_id;
        state_n       = ST_IDLE;
      end
      default: state_n = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= ST_IDLE;
      last_grant  <= REQ_B;
      cur_id      <= REQ_A;
      cur_op      <= OP_PUSH;
      cur_sel     <= SEL_S0;
      cur_ok      <= 1'b0;
      cur_wdata   <= '0;
      wait_cnt    <= '0;
      a_ready     <= 1'b0;
      b_ready     <= 1'b0;
      a_rsp_valid <= 1'b0;
      b_rsp_valid <= 1'b0;
      a_rsp_ok    <= 1'b0;
      b_rsp_ok    <= 1'b0;
      a_rsp_data  <= '0;
      b_rsp_data  <= '0;
      dq_select   <= 1'b0;
      dq_push     <= 1'b0;
      dq_pop      <= 1'b0;
      dq_data_in  <= '0;
      busy        <= 1'b0;
    end else begin
      state       <= state_n;
      last_grant  <= last_grant_n;
      cur_id      <= cur_id_n;
      cur_op      <= cur_op_n;
      cur_sel     <= cur_sel_n;
      cur_ok      <= cur_ok_n;
      cur_wdata   <= cur_wdata_n;
      wait_cnt    <= wait_cnt_n;
      a_ready     <= a_ready_n;
      b_ready     <= b_ready_n;
      a_rsp_valid <= a_rsp_valid_n;
      b_rsp_valid <= b_rsp_valid_n;
      a_rsp_ok    <= a_rsp_valid_n & rsp_ok_n;
      b_rsp_ok    <= b_rsp_valid_n & rsp_ok_n;
      a_rsp_data  <= a_rsp_valid_n ? rsp_data_n : '0;
      b_rsp_data  <= b_rsp_valid_n ? rsp_data_n : '0;
      dq_select   <= dq_select_n;
      dq_push     <= dq_push_n;
      dq_pop      <= dq_pop_n;
      dq_data_in  <= dq_data_in_n;
      busy        <= (state_n != ST_IDLE);
    end
  end

endmodule

// File: tb/tb_dual_deque_arbiter.sv
// Directed and random bench for dual_deque_arbiter against a queue-based deque model.
module tb_dual_deque_arbiter;
  localparam int DATA_W      = 8;
  localparam int POP_LATENCY = 1;
  localparam int DEPTH       = 4;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              a_req, a_op, a_sel, b_req, b_op, b_sel;
  logic [DATA_W-1:0] a_wdata, b_wdata;
  logic              a_ready, a_rsp_valid, a_rsp_ok, b_ready, b_rsp_valid, b_rsp_ok;
  logic [DATA_W-1:0] a_rsp_data, b_rsp_data;
  logic              dq_select, dq_push, dq_pop;
  logic [DATA_W-1:0] dq_data_in, dq_data_out;
  logic              dq_s0_empty, dq_s0_full, dq_s1_empty, dq_s1_full, busy;

  dual_deque_arbiter #(.DATA_W(DATA_W), .POP_LATENCY(POP_LATENCY)) dut (
    .clk(clk), .rst_n(rst_n),
    .a_req(a_req), .a_op(a_op), .a_sel(a_sel), .a_wdata(a_wdata),
    .a_ready(a_ready), .a_rsp_valid(a_rsp_valid), .a_rsp_ok(a_rsp_ok), .a_rsp_data(a_rsp_data),
    .b_req(b_req), .b_op(b_op), .b_sel(b_sel), .b_wdata(b_wdata),
    .b_ready(b_ready), .b_rsp_valid(b_rsp_valid), .b_rsp_ok(b_rsp_ok), .b_rsp_data(b_rsp_data),
    .dq_select(dq_select), .dq_push(dq_push), .dq_pop(dq_pop),
    .dq_data_in(dq_data_in), .dq_data_out(dq_data_out),
    .dq_s0_empty(dq_s0_empty), .dq_s0_full(dq_s0_full),
    .dq_s1_empty(dq_s1_empty), .dq_s1_full(dq_s1_full),
    .busy(busy)
  );

  always #5 clk = ~clk;

  // Deque stand-in driven by the DUT strobes (stack per side, one-cycle pop latency).
  logic [DATA_W-1:0] mem0 [DEPTH];
  logic [DATA_W-1:0] mem1 [DEPTH];
  int cnt0, cnt1;
  always @(posedge clk) begin
    if (!rst_n) begin
      cnt0 <= 0; cnt1 <= 0; dq_data_out <= '0;
    end else begin
      if (dq_push) begin
        if (dq_select) begin mem1[cnt1] <= dq_data_in; cnt1 <= cnt1 + 1; end
        else           begin mem0[cnt0] <= dq_data_in; cnt0 <= cnt0 + 1; end
      end
      if (dq_pop) begin
        if (dq_select) begin dq_data_out <= mem1[cnt1-1]; cnt1 <= cnt1 - 1; end
        else           begin dq_data_out <= mem0[cnt0-1]; cnt0 <= cnt0 - 1; end
      end
    end
  end
  assign dq_s0_empty = (cnt0 <= 0);
  assign dq_s0_full  = (cnt0 >= DEPTH);
  assign dq_s1_empty = (cnt1 <= 0);
  assign dq_s1_full  = (cnt1 >= DEPTH);

  // Reference model state
  logic [DATA_W-1:0] rq0[$], rq1[$];
  bit                ref_last;
  bit                pend_v[2], pend_op[2], pend_sel[2];
  logic [DATA_W-1:0] pend_wd[2];
  int                n_assert = 0, n_fail = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_zero(input string tag);
    chk({tag, "_a_b_out"}, {10'd0, a_ready, a_rsp_valid, a_rsp_ok, a_rsp_data,
                            b_ready, b_rsp_valid, b_rsp_ok, b_rsp_data}, 32'd0);
    chk({tag, "_dq_busy"}, {20'd0, dq_select, dq_push, dq_pop, dq_data_in, busy}, 32'd0);
  endtask

  task automatic drive_reqs();
    a_req = pend_v[0]; a_op = pend_op[0]; a_sel = pend_sel[0]; a_wdata = pend_wd[0];
    b_req = pend_v[1]; b_op = pend_op[1]; b_sel = pend_sel[1]; b_wdata = pend_wd[1];
  endtask

  task automatic set_cmd(input int who, input bit op, input bit sel, input logic [DATA_W-1:0] wd);
    pend_v[who] = 1'b1; pend_op[who] = op; pend_sel[who] = sel; pend_wd[who] = wd;
    drive_reqs();
  endtask

  task automatic clear_ref();
    pend_v[0] = 1'b0; pend_v[1] = 1'b0;
    drive_reqs();
    rq0.delete(); rq1.delete();
    ref_last = 1'b1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    clear_ref();
    repeat (2) @(posedge clk);
    #1;
    check_zero("reset");
    rst_n = 1'b1;
  endtask

  // Serve one grant and check the whole command timeline against the model.
  task automatic serve();
    bit got, win, exp_win, exp_ok, done, other_rsp, op, sel;
    logic [DATA_W-1:0] wd, exp_data, obs_data;
    int exp_lat, rsp_cyc, n_strb, strb_cyc, sz;
    drive_reqs();
    got = 1'b0;
    for (int i = 0; i < 10 && !got; i++) begin
      @(posedge clk); #1;
      got = a_ready | b_ready;
    end
    chk("ready_seen", 32'(got), 32'd1);
    if (!got) begin
      pend_v[0] = 1'b0; pend_v[1] = 1'b0; drive_reqs();
      return;
    end
    chk("single_ready", 32'(a_ready & b_ready), 32'd0);
    chk("busy_at_ready", 32'(busy), 32'd1);
    win     = b_ready;
    exp_win = (pend_v[0] && pend_v[1]) ? !ref_last : pend_v[1];
    chk("grant", 32'(win), 32'(exp_win));
    op = pend_op[win]; sel = pend_sel[win]; wd = pend_wd[win];
    exp_data = '0;
    sz = sel ? rq1.size() : rq0.size();
    if (!op) begin
      exp_ok = (sz < DEPTH);
      if (exp_ok) begin
        if (sel) rq1.push_back(wd); else rq0.push_back(wd);
      end
      exp_lat = exp_ok ? 2 : 1;
    end else begin
      exp_ok = (sz > 0);
      if (exp_ok) exp_data = sel ? rq1.pop_back() : rq0.pop_back();
      exp_lat = exp_ok ? 2 + POP_LATENCY : 1;
    end
    pend_v[win] = 1'b0;
    drive_reqs();
    done = 1'b0; other_rsp = 1'b0; rsp_cyc = -1; n_strb = 0; strb_cyc = -1;
    for (int k = 1; k <= 8 && !done; k++) begin
      @(posedge clk); #1;
      chk("push_pop_excl", 32'(dq_push & dq_pop), 32'd0);
      chk("no_ready_inflight", 32'(a_ready | b_ready), 32'd0);
      if (dq_push | dq_pop) begin
        n_strb++; strb_cyc = k;
        chk("strobe_kind", 32'(dq_pop), 32'(op));
        chk("strobe_sel", 32'(dq_select), 32'(sel));
        if (!op) chk("strobe_data", 32'(dq_data_in), 32'(wd));
      end
      if (win ? a_rsp_valid : b_rsp_valid) other_rsp = 1'b1;
      if (win ? b_rsp_valid : a_rsp_valid) begin
        done = 1'b1; rsp_cyc = k;
        obs_data = win ? b_rsp_data : a_rsp_data;
        chk("rsp_ok", 32'(win ? b_rsp_ok : a_rsp_ok), 32'(exp_ok));
        chk("rsp_data", 32'(obs_data), 32'(exp_data));
        chk("busy_at_rsp", 32'(busy), 32'd0);
      end
    end
    chk("rsp_latency", 32'(rsp_cyc), 32'(exp_lat));
    chk("strobe_count", 32'(n_strb), 32'(exp_ok));
    chk("no_cross_rsp", 32'(other_rsp), 32'd0);
    if (exp_ok) chk("strobe_cycle", 32'(strb_cyc), 32'd1);
    ref_last = win;
  endtask

  initial begin
    bit got;
    rst_n = 1'b0;
    do_reset();

    // A push s0 0x5A, A pop s0, B pop empty s1
    set_cmd(0, 1'b0, 1'b0, 8'h5A); serve();
    set_cmd(0, 1'b1, 1'b0, 8'h00); serve();
    set_cmd(1, 1'b1, 1'b1, 8'h00); serve();

    // Both requesting for four commands right after reset: A,B,A,B
    do_reset();
    set_cmd(0, 1'b0, 1'b0, 8'h11);
    set_cmd(1, 1'b0, 1'b1, 8'h22);
    serve();
    set_cmd(0, 1'b0, 1'b0, 8'h33);
    serve();
    set_cmd(1, 1'b1, 1'b1, 8'h00);
    serve();
    set_cmd(0, 1'b0, 1'b0, 8'h44);
    serve();
    serve();

    // Fill s1, then B pushes to full s1 while A pops non-empty s0
    for (int i = 0; i < DEPTH; i++) begin
      set_cmd(1, 1'b0, 1'b1, 8'(8'hC0 + i)); serve();
    end
    set_cmd(0, 1'b1, 1'b0, 8'h00);
    set_cmd(1, 1'b0, 1'b1, 8'h99);
    serve();
    serve();

    // Reset while waiting on pop data aborts the command
    do_reset();
    set_cmd(0, 1'b0, 1'b0, 8'h77); serve();
    set_cmd(0, 1'b1, 1'b0, 8'h00);
    got = 1'b0;
    for (int i = 0; i < 10 && !got; i++) begin
      @(posedge clk); #1;
      got = a_ready;
    end
    chk("abort_ready_seen", 32'(got), 32'd1);
    pend_v[0] = 1'b0; drive_reqs();
    @(posedge clk); #1;
    chk("abort_pop_strobe", 32'(dq_pop), 32'd1);
    rst_n = 1'b0;
    @(posedge clk); #1;
    check_zero("abort");
    rst_n = 1'b1;
    clear_ref();
    for (int i = 0; i < 6; i++) begin
      @(posedge clk); #1;
      chk("abort_quiet", 32'({a_rsp_valid, b_rsp_valid, a_ready, b_ready, dq_push, dq_pop}), 32'd0);
    end

    // Random traffic
    do_reset();
    for (int it = 0; it < 80; it++) begin
      for (int w = 0; w < 2; w++) begin
        if (!pend_v[w] && $urandom_range(0, 3) != 0)
          set_cmd(w, ($urandom_range(0, 9) >= 5), 1'($urandom_range(0, 1)), 8'($urandom_range(0, 255)));
      end
      if (pend_v[0] || pend_v[1]) serve();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
